alu_cmd_sequencer: RTL and testbench
====================================

// Module: alu_cmd_sequencer
// PURPOSE
//  Upstream issue stage for the 4-bit ALU (x, y, select[3:0] -> out[3:0], c_out).
//  Buffers commands in a small FIFO and drives one command at a time onto the ALU port.
//  Captures the ALU result, carry, zero and error flags into a response register with valid/ready.
//  Keeps an accumulator so that chained ops can take x from the previous result.
// PARAMETERS
//  WIDTH     4     operand width; must equal the ALU width (4)
//  DEPTH     4     command FIFO entries; power of two, >= 2
//  ACC_INIT  4'h0  accumulator value after reset
// PORTS
//  clk          in   1      rising-edge clock
//  reset_n      in   1      asynchronous reset, active-low
//  cmd_valid    in   1      command offered
//  cmd_ready    out  1      FIFO can accept; equals !full
//  cmd_select   in   4      ALU opcode (0x0-0xB legal)
//  cmd_x        in   WIDTH  x operand; ignored when cmd_use_acc=1
//  cmd_y        in   WIDTH  y operand
//  cmd_use_acc  in   1      1: use acc as x
//  alu_x        out  WIDTH  to ALU x
//  alu_y        out  WIDTH  to ALU y
//  alu_select   out  4      to ALU select
//  alu_out      in   WIDTH  from ALU (combinational)
//  alu_c_out    in   1      from ALU
//  rsp_valid    out  1      response held
//  rsp_ready    in   1      consumer accepts
//  rsp_out      out  WIDTH  captured result
//  rsp_c_out    out  1      captured carry; forced 0 for logic ops
//  rsp_zero     out  1      rsp_out == 0
//  rsp_err      out  1      opcode 0xC-0xF
//  acc          out  WIDTH  accumulator
//  ops_done     out  8      completed-op counter; wraps 0xFF->0x00
// BEHAVIOUR
//  Reset: FIFO empty and cmd_ready=1. rsp_* = 0. acc = ACC_INIT. ops_done = 0. State IDLE. alu_* = 0.
//  Push: occurs on cmd_valid & cmd_ready. The stored entry is {select, x, y, use_acc}. Order is FIFO; no push when full.
//  FSM IDLE: alu_* = 0. Go to EXEC when the FIFO is non-empty.
//  FSM EXEC (exactly 1 cycle):
//   - Drive alu_select=head.select, alu_y=head.y, alu_x = head.use_acc ? acc : head.x.
//   - At the clock edge: pop the head and capture alu_out and alu_c_out into rsp_*. Set rsp_valid=1. Go to HOLD.
//  FSM HOLD: hold rsp_* stable and alu_* = 0.
//   - On rsp_ready: clear rsp_valid. Go to EXEC if the FIFO is non-empty, else IDLE.
//  Latency: a command pushed at edge N is driven in the EXEC cycle after it. rsp_valid rises at edge N+2 when the block is IDLE.
//  Throughput: one op per 2 cycles with rsp_ready held at 1.
//  Opcode 0x8-0xB: rsp_c_out = 0.
//  Opcode 0xC-0xF: rsp_out = 0, rsp_c_out = 0, rsp_err = 1. acc and ops_done are unchanged. The response is still issued.
//  Legal op: acc <= alu_out and ops_done += 1, both at the EXEC edge. rsp_err = 0.
//  Push while full is blocked. Push and pop in the same cycle is allowed when not full; occupancy is then unchanged.
//  A push into an empty FIFO is visible to the FSM next cycle; there is no same-cycle bypass.
//  Reset mid-operation: all state is cleared immediately (asynchronous). FIFO contents and in-flight responses are discarded.
// STRUCTURE
//  Shared package alu_pkg: SEL_* opcode localparams (0x0 TRANSFER .. 0xB NOT), is_logic/is_legal helpers, FSM state encoding.
//  Sub-module alu_cmd_fifo: DEPTH x (4+2*WIDTH+1) register FIFO with wrapping pointers and a count.
//  The ALU itself stays outside this block and is connected at the parent level.
// TESTING (bench instantiates this block plus the ALU)
//  1. Hold reset_n=0, then release -> cmd_ready=1, rsp_valid=0, acc=0, ops_done=0, alu_select=0.
//  2. Push sel=2, x=9, y=8 at edge N -> EXEC shows alu_x=9, alu_y=8. At edge N+2: rsp_out=1, c_out=1, zero=0, acc=1.
//  3. Chain from acc=1:
//     - sel=1 with use_acc -> rsp_out=2.
//     - Then sel=6 with use_acc -> rsp_out=1, c_out=1.
//     - Then sel=5, x=3, y=3 -> rsp_out=0, zero=1, c_out=1.
//  4. Hold rsp_ready=0 and push 6 commands:
//     - 1 command sits in HOLD and 4 fill the FIFO; cmd_ready=0 blocks the 6th.
//     - Release -> 5 responses in push order, then the 6th is accepted.
//  5. Push sel=8, x=F, y=A -> rsp_out=A, c_out=0. Push sel=D -> rsp_err=1, rsp_out=0, acc and ops_done unchanged.
//  6. Pull reset_n low while in HOLD with 3 entries queued -> rsp_valid=0 asynchronously, FIFO empty, no response after release.

Source files
------------

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - opcode map, opcode class helpers and sequencer state encoding
package alu_pkg;

    localparam logic [3:0] SEL_TRANSFER   = 4'h0;
    localparam logic [3:0] SEL_INC        = 4'h1;
    localparam logic [3:0] SEL_ADD        = 4'h2;
    localparam logic [3:0] SEL_ADD_INC    = 4'h3;
    localparam logic [3:0] SEL_SUB_BORROW = 4'h4;
    localparam logic [3:0] SEL_SUB        = 4'h5;
    localparam logic [3:0] SEL_DEC        = 4'h6;
    localparam logic [3:0] SEL_TRANSFER_C = 4'h7;
    localparam logic [3:0] SEL_AND        = 4'h8;
    localparam logic [3:0] SEL_OR         = 4'h9;
    localparam logic [3:0] SEL_XOR        = 4'hA;
    localparam logic [3:0] SEL_NOT        = 4'hB;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_HOLD = 2'd2
    } seq_state_t;

    function automatic logic is_logic(input logic [3:0] sel);
        return (sel >= SEL_AND) && (sel <= SEL_NOT);
    endfunction

    function automatic logic is_legal(input logic [3:0] sel);
        return sel <= SEL_NOT;
    endfunction

endpackage

// File: rtl/alu_cmd_fifo.sv
// rtl/alu_cmd_fifo.sv - register FIFO holding queued ALU commands
module alu_cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int DW    = 13
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          push,
    input  logic [DW-1:0] push_data,
    input  logic          pop,
    output logic [DW-1:0] head,
    output logic          full,
    output logic          empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = DEPTH[AW:0];

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == FULL_COUNT);
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    // Storage needs no reset: empty/count gate every read.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// rtl/alu_cmd_sequencer.sv - queues ALU commands, issues one at a time, registers responses
module alu_cmd_sequencer
    import alu_pkg::*;
#(
    parameter int               WIDTH    = 4,
    parameter int               DEPTH    = 4,
    parameter logic [WIDTH-1:0] ACC_INIT = '0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [3:0]       cmd_select,
    input  logic [WIDTH-1:0] cmd_x,
    input  logic [WIDTH-1:0] cmd_y,
    input  logic             cmd_use_acc,
    output logic [WIDTH-1:0] alu_x,
    output logic [WIDTH-1:0] alu_y,
    output logic [3:0]       alu_select,
    input  logic [WIDTH-1:0] alu_out,
    input  logic             alu_c_out,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_out,
    output logic             rsp_c_out,
    output logic             rsp_zero,
    output logic             rsp_err,
    output logic [WIDTH-1:0] acc,
    output logic [7:0]       ops_done
);

    typedef struct packed {
        logic [3:0]       select;
        logic [WIDTH-1:0] x;
        logic [WIDTH-1:0] y;
        logic             use_acc;
    } cmd_t;

    localparam int EW = $bits(cmd_t);

    cmd_t       push_cmd;
    cmd_t       head_cmd;
    logic       fifo_full;
    logic       fifo_empty;
    logic       exec;
    logic       head_legal;
    seq_state_t state;
    seq_state_t next_state;

    assign push_cmd   = '{select: cmd_select, x: cmd_x, y: cmd_y, use_acc: cmd_use_acc};
    assign cmd_ready  = !fifo_full;
    assign exec       = (state == ST_EXEC);
    assign head_legal = is_legal(head_cmd.select);

    alu_cmd_fifo #(
        .DEPTH (DEPTH),
        .DW    (EW)
    ) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (cmd_valid),
        .push_data (push_cmd),
        .pop       (exec),
        .head      (head_cmd),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        alu_x      = '0;
        alu_y      = '0;
        alu_select = '0;
        case (state)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    next_state = ST_EXEC;
                end
            end
            ST_EXEC: begin
                alu_select = head_cmd.select;
                alu_y      = head_cmd.y;
                alu_x      = head_cmd.use_acc ? acc : head_cmd.x;
                next_state = ST_HOLD;
            end
            ST_HOLD: begin
                if (rsp_ready) begin
                    next_state = fifo_empty ? ST_IDLE : ST_EXEC;
                end
            end
            default: next_state = ST_IDLE;
        endcase
    end

    // Illegal opcodes still produce a response, but never touch acc or ops_done.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rsp_valid <= 1'b0;
            rsp_out   <= '0;
            rsp_c_out <= 1'b0;
            rsp_zero  <= 1'b0;
            rsp_err   <= 1'b0;
            acc       <= ACC_INIT;
            ops_done  <= '0;
        end else if (exec) begin
            rsp_valid <= 1'b1;
            rsp_out   <= head_legal ? alu_out : '0;
            rsp_c_out <= head_legal && !is_logic(head_cmd.select) && alu_c_out;
            rsp_zero  <= !head_legal || (alu_out == '0);
            rsp_err   <= !head_legal;
            if (head_legal) begin
                acc      <= alu_out;
                ops_done <= ops_done + 8'd1;
            end
        end else if ((state == ST_HOLD) && rsp_ready) begin
            rsp_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// tb/tb_alu_cmd_sequencer.sv - directed and randomized bench for alu_cmd_sequencer with a 4-bit ALU
module tb_alu_cmd_sequencer;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [3:0] cmd_select;
    logic [3:0] cmd_x;
    logic [3:0] cmd_y;
    logic       cmd_use_acc;
    logic [3:0] alu_x;
    logic [3:0] alu_y;
    logic [3:0] alu_select;
    logic [3:0] alu_out;
    logic       alu_c_out;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [3:0] rsp_out;
    logic       rsp_c_out;
    logic       rsp_zero;
    logic       rsp_err;
    logic [3:0] acc;
    logic [7:0] ops_done;

    typedef struct packed {
        logic [3:0] sel;
        logic [3:0] x;
        logic [3:0] y;
        logic       ua;
    } tcmd_t;

    tcmd_t mq[$];
    int    n_pass = 0;
    int    n_total = 0;
    int    n_acc = 0;
    int    acc_target = 0;
    int    m_acc = 0;
    int    m_ops = 0;
    logic [4:0] alu_res;

    always #5 clk = ~clk;

    alu_cmd_sequencer dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_select  (cmd_select),
        .cmd_x       (cmd_x),
        .cmd_y       (cmd_y),
        .cmd_use_acc (cmd_use_acc),
        .alu_x       (alu_x),
        .alu_y       (alu_y),
        .alu_select  (alu_select),
        .alu_out     (alu_out),
        .alu_c_out   (alu_c_out),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_out     (rsp_out),
        .rsp_c_out   (rsp_c_out),
        .rsp_zero    (rsp_zero),
        .rsp_err     (rsp_err),
        .acc         (acc),
        .ops_done    (ops_done)
    );

    // External ALU; logic and illegal ops return junk carry/result so forcing is observable.
    always_comb begin
        alu_res = 5'h1F;
        case (alu_select)
            4'h0: alu_res = {1'b0, alu_x};
            4'h1: alu_res = {1'b0, alu_x} + 5'd1;
            4'h2: alu_res = {1'b0, alu_x} + {1'b0, alu_y};
            4'h3: alu_res = {1'b0, alu_x} + {1'b0, alu_y} + 5'd1;
            4'h4: alu_res = {1'b0, alu_x} + {1'b0, ~alu_y};
            4'h5: alu_res = {1'b0, alu_x} + {1'b0, ~alu_y} + 5'd1;
            4'h6: alu_res = {1'b0, alu_x} + 5'h0F;
            4'h7: alu_res = {1'b0, alu_x} + 5'h10;
            4'h8: alu_res = {1'b1, alu_x & alu_y};
            4'h9: alu_res = {1'b1, alu_x | alu_y};
            4'hA: alu_res = {1'b1, alu_x ^ alu_y};
            4'hB: alu_res = {1'b1, ~alu_x};
            default: alu_res = 5'h1F;
        endcase
    end
    assign alu_out   = alu_res[3:0];
    assign alu_c_out = alu_res[4];

    always @(posedge clk) begin
        if (reset_n && cmd_valid && cmd_ready) begin
            mq.push_back('{sel: cmd_select, x: cmd_x, y: cmd_y, ua: cmd_use_acc});
            n_acc++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (cmd_valid && (n_acc >= acc_target)) cmd_valid = 1'b0;
    endtask

    task automatic offer(input logic [3:0] sel, input logic [3:0] x, input logic [3:0] y, input logic ua);
        cmd_select  = sel;
        cmd_x       = x;
        cmd_y       = y;
        cmd_use_acc = ua;
        acc_target  = n_acc + 1;
        cmd_valid   = 1'b1;
    endtask

    task automatic push(input logic [3:0] sel, input logic [3:0] x, input logic [3:0] y, input logic ua);
        int w = 0;
        offer(sel, x, y, ua);
        while (cmd_valid && w < 40) begin
            tick();
            w++;
        end
        chk("push_accepted", {31'd0, cmd_valid}, 32'd0);
    endtask

    // Reference: each response corresponds to the oldest accepted command, evaluated with plain arithmetic.
    task automatic expect_rsp();
        tcmd_t c;
        int    w = 0;
        int    xv;
        int    r;
        logic [3:0] eo;
        logic  ec;
        logic  ee;
        while (!rsp_valid && w < 50) begin
            tick();
            w++;
        end
        chk("rsp_valid_seen", {31'd0, rsp_valid}, 32'd1);
        chk("model_has_cmd", {31'd0, mq.size() != 0}, 32'd1);
        if (mq.size() == 0) return;
        c  = mq.pop_front();
        xv = c.ua ? m_acc : int'(c.x);
        case (c.sel)
            4'h0: r = xv;
            4'h1: r = xv + 1;
            4'h2: r = xv + int'(c.y);
            4'h3: r = xv + int'(c.y) + 1;
            4'h4: r = xv + 15 - int'(c.y);
            4'h5: r = xv + 16 - int'(c.y);
            4'h6: r = xv + 15;
            4'h7: r = xv + 16;
            4'h8: r = xv & int'(c.y);
            4'h9: r = xv | int'(c.y);
            4'hA: r = xv ^ int'(c.y);
            4'hB: r = 15 - xv;
            default: r = 0;
        endcase
        ee = (c.sel >= 4'hC);
        ec = (c.sel < 4'h8) && (r >= 16);
        eo = ee ? 4'h0 : 4'(r % 16);
        if (!ee) begin
            m_acc = int'(eo);
            m_ops = (m_ops + 1) % 256;
        end
        chk("rsp_out", {28'd0, rsp_out}, {28'd0, eo});
        chk("rsp_c_out", {31'd0, rsp_c_out}, {31'd0, ec});
        chk("rsp_zero", {31'd0, rsp_zero}, {31'd0, eo == 4'h0});
        chk("rsp_err", {31'd0, rsp_err}, {31'd0, ee});
        chk("acc", {28'd0, acc}, m_acc);
        chk("ops_done", {24'd0, ops_done}, m_ops);
    endtask

    task automatic consume();
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
    endtask

    initial begin
        int base;
        int seen;
        reset_n     = 1'b0;
        cmd_valid   = 1'b0;
        cmd_select  = 4'h0;
        cmd_x       = 4'h0;
        cmd_y       = 4'h0;
        cmd_use_acc = 1'b0;
        rsp_ready   = 1'b0;

        // 1. reset state
        repeat (3) tick();
        reset_n = 1'b1;
        tick();
        chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_acc", {28'd0, acc}, 32'd0);
        chk("rst_ops_done", {24'd0, ops_done}, 32'd0);
        chk("rst_alu_select", {28'd0, alu_select}, 32'd0);
        chk("rst_rsp_out", {28'd0, rsp_out}, 32'd0);

        // 2. latency and first add
        push(4'h2, 4'h9, 4'h8, 1'b0);
        chk("lat_n_valid", {31'd0, rsp_valid}, 32'd0);
        chk("lat_n_select", {28'd0, alu_select}, 32'd0);
        tick();
        chk("exec_alu_x", {28'd0, alu_x}, 32'd9);
        chk("exec_alu_y", {28'd0, alu_y}, 32'd8);
        chk("exec_alu_select", {28'd0, alu_select}, 32'd2);
        tick();
        chk("lat_n2_valid", {31'd0, rsp_valid}, 32'd1);
        chk("hold_alu_select", {28'd0, alu_select}, 32'd0);
        expect_rsp();
        chk("add_out", {28'd0, rsp_out}, 32'd1);
        chk("add_c", {31'd0, rsp_c_out}, 32'd1);
        chk("add_acc", {28'd0, acc}, 32'd1);
        consume();

        // 3. accumulator chaining
        push(4'h1, 4'h7, 4'h0, 1'b1);
        expect_rsp();
        chk("chain_inc", {28'd0, rsp_out}, 32'd2);
        consume();
        push(4'h6, 4'hE, 4'h0, 1'b1);
        expect_rsp();
        chk("chain_dec", {28'd0, rsp_out}, 32'd1);
        chk("chain_dec_c", {31'd0, rsp_c_out}, 32'd1);
        consume();
        push(4'h5, 4'h3, 4'h3, 1'b0);
        expect_rsp();
        chk("sub_zero", {31'd0, rsp_zero}, 32'd1);
        chk("sub_c", {31'd0, rsp_c_out}, 32'd1);
        consume();

        // 4. backpressure: one in HOLD, four queued, sixth blocked
        base = n_acc;
        for (int i = 0; i < 5; i++) push(4'h2, 4'(i + 1), 4'(3 * i), 1'b0);
        offer(4'h3, 4'h4, 4'h4, 1'b0);
        repeat (3) tick();
        chk("full_ready_low", {31'd0, cmd_ready}, 32'd0);
        chk("full_accepted", n_acc, base + 5);
        chk("full_rsp_valid", {31'd0, rsp_valid}, 32'd1);
        for (int i = 0; i < 6; i++) begin
            expect_rsp();
            consume();
        end
        chk("sixth_accepted", n_acc, base + 6);

        // 5. logic op carry forcing and illegal opcode
        push(4'h8, 4'hF, 4'hA, 1'b0);
        expect_rsp();
        chk("and_out", {28'd0, rsp_out}, 32'hA);
        chk("and_c", {31'd0, rsp_c_out}, 32'd0);
        consume();
        base = m_ops;
        push(4'hD, 4'h5, 4'h6, 1'b0);
        expect_rsp();
        chk("err_flag", {31'd0, rsp_err}, 32'd1);
        chk("err_out", {28'd0, rsp_out}, 32'd0);
        chk("err_acc", {28'd0, acc}, 32'hA);
        chk("err_ops", {24'd0, ops_done}, base);
        consume();

        // randomized bursts against the reference
        for (int it = 0; it < 25; it++) begin
            int k;
            k = int'($urandom_range(1, 3));
            for (int j = 0; j < k; j++) begin
                push(4'($urandom_range(0, 15)), 4'($urandom), 4'($urandom), 1'($urandom));
            end
            for (int j = 0; j < k; j++) begin
                expect_rsp();
                repeat ($urandom_range(0, 2)) tick();
                chk("rnd_rsp_hold", {31'd0, rsp_valid}, 32'd1);
                consume();
            end
        end

        // 6. asynchronous reset while holding with three queued
        for (int i = 0; i < 4; i++) push(4'h2, 4'(i), 4'h1, 1'b0);
        seen = 0;
        while (!rsp_valid && seen < 20) begin
            tick();
            seen++;
        end
        chk("pre_reset_valid", {31'd0, rsp_valid}, 32'd1);
        #3;
        reset_n = 1'b0;
        #1;
        chk("async_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("async_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        chk("async_acc", {28'd0, acc}, 32'd0);
        chk("async_ops", {24'd0, ops_done}, 32'd0);
        mq.delete();
        m_acc = 0;
        m_ops = 0;
        tick();
        reset_n   = 1'b1;
        rsp_ready = 1'b1;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (rsp_valid || alu_select != 4'h0) seen++;
        end
        rsp_ready = 1'b0;
        chk("no_rsp_after_reset", seen, 32'd0);
        chk("post_reset_ops", {24'd0, ops_done}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
